// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses a 1-cycle-latency instruction memory and hands
// instructions to decode over valid/ready. Optional FETCH_PERF_EN adds saturating perf counters.
module instr_fetch_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stalls,
    output logic [31:0]           perf_redirects,
`endif
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StStall = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ResetPc = RESET_PC[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic                  stall;

    assign out_valid = (state_q != StIdle) && !redirect_valid;
    assign stall     = out_valid && !out_ready;
    assign out_instr = imem_rdata;
    assign out_pc    = rsp_pc_q;

    always_comb begin
        // A refused instruction re-reads its own word so the registered data stays stable.
        if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = rsp_pc_q;
        end else begin
            imem_addr = pc_q;
        end
    end

    always_comb begin
        rsp_pc_d = imem_addr;
        pc_d     = imem_addr + AddrOne;
        state_d  = StRun;
        if (state_q != StIdle && !redirect_valid && stall) begin
            state_d = StStall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= ResetPc;
            rsp_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stalls_q, stalls_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        fetched_d   = fetched_q;
        stalls_d    = stalls_q;
        redirects_d = redirects_q;
        if (out_valid && out_ready && fetched_q != 32'hFFFF_FFFF) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (stall && stalls_q != 32'hFFFF_FFFF) begin
            stalls_d = stalls_q + 32'd1;
        end
        if (redirect_valid && redirects_q != 32'hFFFF_FFFF) begin
            redirects_d = redirects_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q   <= '0;
            stalls_q    <= '0;
            redirects_q <= '0;
        end else begin
            fetched_q   <= fetched_d;
            stalls_q    <= stalls_d;
            redirects_q <= redirects_d;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_stalls    = stalls_q;
    assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic
// checked every cycle against a stream-level model of which PC must be presented next.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_redirects;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    // Stream model: is an instruction due, and which PC must it be.
    logic        m_live = 1'b0;
    logic [7:0]  m_pc = 8'd0;
    int unsigned m_fetched = 0, m_stalls = 0, m_redirects = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
`ifdef FETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls),
        .perf_redirects(perf_redirects),
`endif
        .out_pc        (out_pc)
    );

    // Instruction memory: 1-cycle registered read, output 0 in reset.
    always @(posedge clk or posedge rst) begin
        if (rst) imem_rdata <= '0;
        else     imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare and model advance (inputs are stable from posedge+1 to next posedge).
    always @(negedge clk) begin
        logic       ev;
        logic [7:0] ea;
        if (rst) begin
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_pc", 64'(out_pc), 64'd0);
            chk("rst_addr", 64'(imem_addr), 64'd0);
`ifdef FETCH_PERF_EN
            chk("rst_perf_fetched", 64'(perf_fetched), 64'd0);
            chk("rst_perf_stalls", 64'(perf_stalls), 64'd0);
            chk("rst_perf_redirects", 64'(perf_redirects), 64'd0);
`endif
            m_live = 1'b0;
            m_pc = 8'd0;
            m_fetched = 0;
            m_stalls = 0;
            m_redirects = 0;
        end else begin
            ev = m_live && !redirect_valid;
            chk("valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                chk("pc", 64'(out_pc), 64'(m_pc));
                chk("instr", 64'(out_instr), 64'(mem[m_pc]));
            end
            if (redirect_valid)         ea = redirect_pc;
            else if (ev && !out_ready)  ea = m_pc;
            else if (m_live)            ea = m_pc + 8'd1;
            else                        ea = m_pc;
            chk("addr", 64'(imem_addr), 64'(ea));
            if (ev && out_ready)  m_fetched++;
            if (ev && !out_ready) m_stalls++;
            if (redirect_valid)   m_redirects++;
            if (redirect_valid) begin
                m_live = 1'b1;
                m_pc = redirect_pc;
            end else if (!m_live) begin
                m_live = 1'b1;
            end else if (out_ready) begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    task automatic cyc(input logic rdy, input logic rv, input logic [7:0] rpc);
        @(posedge clk);
        #1;
        out_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic v, input logic [7:0] pc,
                       input logic [31:0] instr);
        chk({name, "_valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            chk({name, "_pc"}, 64'(out_pc), 64'(pc));
            chk({name, "_instr"}, 64'(out_instr), 64'(instr));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h1234_5678;
        mem[1] = 32'h8765_4321;
        mem[2] = 32'h0000_000A;
        mem[3] = 32'h0000_000B;

        repeat (3) @(posedge clk);
        #1 chk("rst_addr_lit", 64'(imem_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 lit("idle", 1'b0, 8'd0, 32'd0);

        cyc(1, 0, 0); lit("seq0", 1'b1, 8'd0, 32'h1234_5678);
        cyc(1, 0, 0); lit("seq1", 1'b1, 8'd1, 32'h8765_4321);
        cyc(1, 0, 0); lit("seq2", 1'b1, 8'd2, 32'h0000_000A);
        cyc(1, 0, 0); lit("seq3", 1'b1, 8'd3, 32'h0000_000B);
        cyc(1, 0, 0); lit("seq4", 1'b1, 8'd4, mem[4]);

        // Redirect while pc 5 would be shown: killed, then target, never 6.
        cyc(1, 1, 8'h40); lit("redir_kill", 1'b0, 8'd0, 32'd0);
        cyc(1, 0, 0);     lit("redir_tgt", 1'b1, 8'h40, mem[8'h40]);
        cyc(1, 0, 0);     lit("redir_next", 1'b1, 8'h41, mem[8'h41]);

        // Redirect beats a simultaneous stall.
        cyc(0, 1, 8'h00); lit("redir_stall", 1'b0, 8'd0, 32'd0);
        cyc(1, 0, 0);     lit("redir2_tgt", 1'b1, 8'd0, 32'h1234_5678);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            lit("stall_hold", 1'b1, 8'd1, 32'h8765_4321);
            chk("stall_addr", 64'(imem_addr), 64'd1);
        end
        cyc(1, 0, 0); lit("stall_accept", 1'b1, 8'd1, 32'h8765_4321);
        cyc(1, 0, 0); lit("stall_after", 1'b1, 8'd2, 32'h0000_000A);

        cyc(1, 1, 8'hFF); lit("wrap_kill", 1'b0, 8'd0, 32'd0);
        cyc(1, 0, 0);     lit("wrap_ff", 1'b1, 8'hFF, mem[8'hFF]);
        cyc(1, 0, 0);     lit("wrap_00", 1'b1, 8'h00, 32'h1234_5678);
        cyc(1, 0, 0);     lit("wrap_01", 1'b1, 8'h01, 32'h8765_4321);

        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 8'($urandom));
        end

        @(posedge clk);
        #1;
`ifdef FETCH_PERF_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
        chk("perf_redirects", 64'(perf_redirects), 64'(m_redirects));
`endif
        out_ready = 1'b1;
        redirect_valid = 1'b0;

        // Mid-stream reset takes effect immediately.
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_pc", 64'(out_pc), 64'd0);
        chk("midrst_addr", 64'(imem_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 lit("rerst_idle", 1'b0, 8'd0, 32'd0);
        cyc(1, 0, 0); lit("rerst_first", 1'b1, 8'd0, 32'h1234_5678);
        cyc(1, 0, 0); lit("rerst_second", 1'b1, 8'd1, 32'h8765_4321);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
